// File: rtl/ping_seq32.sv
// ping_seq32: issues COUNT ping requests to a downstream engine, with inter-ping gap, per-ping timeout and abort
// Ports: CLK / RST           rising-edge clock, synchronous active-high reset
//        START / ABORT       begin a run (COUNT, GAP latched) / terminate the run in progress
//        COUNT / GAP         pings per run / idle cycles between a completion and the next request
//        PING_DONE           completion pulse from the ping engine
//        PING_REQUEST32      registered one-cycle request to the ping engine
//        BUSY / FINISHED     not idle / registered end-of-run pulse
//        DONE_CNT            pings completed in the current or last run
//        TIMEOUT_ERR         sticky timeout flag for the current or last run
module ping_seq32 #(
  parameter int unsigned TMO_CYCLES = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] COUNT,
  input  logic [7:0] GAP,
  input  logic       PING_DONE,
  output logic       PING_REQUEST32,
  output logic       BUSY,
  output logic       FINISHED,
  output logic [7:0] DONE_CNT,
  output logic       TIMEOUT_ERR
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_GAP} state_t;
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);
  state_t state_q, state_d;
  logic [7:0] rem_q, rem_d, gap_val_q, gap_val_d, gap_cnt_q, gap_cnt_d, done_cnt_q, done_cnt_d;
  logic [15:0] timer_q, timer_d;
  logic tmo_q, tmo_d, req_q, req_d, busy_q, fin_q, fin_d;
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    gap_val_d  = gap_val_q;
    gap_cnt_d  = gap_cnt_q;
    done_cnt_d = done_cnt_q;
    timer_d    = timer_q;
    tmo_d      = tmo_q;
    req_d      = 1'b0;
    fin_d      = 1'b0;
    // abort outranks completion and timeout in every active state
    if (state_q != S_IDLE && ABORT) begin
      state_d = S_IDLE;
      fin_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (START) begin
          done_cnt_d = '0;
          tmo_d      = 1'b0;
          if (COUNT != '0) begin
            rem_d     = COUNT;
            gap_val_d = GAP;
            state_d   = S_REQ;
          end else begin
            fin_d = 1'b1;
          end
        end
        // the request register follows the REQ state by one cycle
        S_REQ: begin
          req_d   = 1'b1;
          timer_d = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          timer_d = timer_q + {15'd0, timer_q != 16'hFFFF};
          if (PING_DONE) begin
            done_cnt_d = done_cnt_q + {7'd0, done_cnt_q != 8'hFF};
            rem_d      = rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              state_d = S_IDLE;
              fin_d   = 1'b1;
            end else if (gap_val_q == '0) begin
              state_d = S_REQ;
            end else begin
              gap_cnt_d = gap_val_q;
              state_d   = S_GAP;
            end
          end else if (timer_q == TMO_LAST) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
            fin_d   = 1'b1;
          end
        end
        S_GAP: begin
          gap_cnt_d = gap_cnt_q - 8'd1;
          state_d   = gap_cnt_q <= 8'd1 ? S_REQ : S_GAP;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      gap_val_q  <= '0;
      gap_cnt_q  <= '0;
      done_cnt_q <= '0;
      timer_q    <= '0;
      tmo_q      <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      gap_val_q  <= gap_val_d;
      gap_cnt_q  <= gap_cnt_d;
      done_cnt_q <= done_cnt_d;
      timer_q    <= timer_d;
      tmo_q      <= tmo_d;
      req_q      <= req_d;
      busy_q     <= state_d != S_IDLE;
      fin_q      <= fin_d;
    end
  end
  assign PING_REQUEST32 = req_q;
  assign BUSY           = busy_q;
  assign FINISHED       = fin_q;
  assign DONE_CNT       = done_cnt_q;
  assign TIMEOUT_ERR    = tmo_q;
endmodule

// File: tb/tb_ping_seq32.sv
// tb_ping_seq32: table-driven, hand-sequenced and randomized checks of ping_seq32 against a schedule model
module tb_ping_seq32;
  localparam int TMO = 16;
  logic clk = 0, rst = 1, start = 0, abort = 0, ping_done = 0;
  logic [7:0] count = 0, gap = 0;
  logic req, busy, fin, tmo_err;
  logic [7:0] done_cnt;
  int checks = 0, failures = 0;
  typedef struct {
    int cnt; int g; int d; int ab; int s2;
    int x_req; int x_fin; int x_done; int x_tmo;
  } vec_t;
  vec_t tbl[13];
  ping_seq32 #(.TMO_CYCLES(TMO)) dut (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .COUNT(count), .GAP(gap),
    .PING_DONE(ping_done), .PING_REQUEST32(req), .BUSY(busy), .FINISHED(fin),
    .DONE_CNT(done_cnt), .TIMEOUT_ERR(tmo_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Edge 0 samples START. The model derives every request, completion and finish edge from
  // the timing rules: first request at edge 1, completion d edges after a request, next request
  // 1 edge later (no gap) or g+1 edges later, timeout TMO edges after a request, abort ends at once.
  task automatic run(input int cnt, input int g, input int dly[8], input int abort_at, input int s2,
                     output int n_req, output int fin_at, output int done_o, output int tmo_o);
    int e[8], dn[8];
    int f, ab, nexp, lastn, xd;
    bit t, xr;
    f = 0; t = 0; nexp = 0; ab = -1;
    for (int i = 0; i < 8; i++) begin e[i] = -1; dn[i] = -1; end
    for (int i = 0; i < cnt && !t; i++) begin
      if (i == 0) e[i] = 1;
      else e[i] = dn[i-1] + (g == 0 ? 1 : g + 1);
      nexp = i + 1;
      if (dly[i] > TMO) begin f = e[i] + TMO; t = 1; end
      else begin dn[i] = e[i] + dly[i]; f = dn[i]; end
    end
    if (abort_at >= 1 && abort_at <= f) begin ab = abort_at; f = ab; t = 0; end
    lastn = (f + 1 > abort_at) ? f + 1 : abort_at;
    for (int i = 0; i < 8; i++) if (dn[i] > lastn) lastn = dn[i];
    n_req = 0; fin_at = -1;
    count = 8'(cnt); gap = 8'(g); start = 1; abort = 0; ping_done = 0;
    for (int n = 0; n <= lastn; n++) begin
      step();
      xr = 0; xd = 0;
      for (int i = 0; i < nexp; i++) begin
        if (e[i] == n && (ab < 0 || e[i] < ab)) xr = 1;
        if (dn[i] >= 0 && dn[i] <= n && (ab < 0 || dn[i] < ab)) xd++;
      end
      chk($sformatf("req@%0d", n), req, xr);
      chk($sformatf("busy@%0d", n), busy, n < f);
      chk($sformatf("finished@%0d", n), fin, n == f);
      chk($sformatf("done_cnt@%0d", n), done_cnt, xd);
      chk($sformatf("timeout@%0d", n), tmo_err, t && n >= f);
      n_req += req;
      if (fin) fin_at = n;
      start = (n + 1 == s2 && s2 <= f);
      if (start) begin count = 8'($urandom_range(1, 7)); gap = 8'($urandom_range(0, 3)); end
      abort = (n + 1 == abort_at);
      ping_done = 0;
      for (int i = 0; i < nexp; i++) if (dn[i] == n + 1 && (ab < 0 || e[i] < ab)) ping_done = 1;
    end
    start = 0; abort = 0; ping_done = 0;
    done_o = done_cnt; tmo_o = tmo_err;
  endtask
  initial begin
    int dly[8];
    int n_req, fin_at, done_o, tmo_o;
    //         cnt g  d   ab  s2  req fin done tmo
    tbl[0]  = '{3, 2, 5,  0,  0,  3,  22, 3,   0};
    tbl[1]  = '{2, 0, 99, 0,  0,  1,  17, 0,   1};
    tbl[2]  = '{1, 0, 16, 0,  0,  1,  17, 1,   0};
    tbl[3]  = '{1, 0, 17, 0,  0,  1,  17, 0,   1};
    tbl[4]  = '{0, 3, 5,  0,  0,  0,  0,  0,   0};
    tbl[5]  = '{4, 0, 3,  7,  3,  2,  7,  1,   0};
    tbl[6]  = '{2, 1, 2,  0,  0,  2,  7,  2,   0};
    tbl[7]  = '{3, 0, 1,  0,  0,  3,  6,  3,   0};
    tbl[8]  = '{2, 3, 4,  1,  0,  0,  1,  0,   0};
    tbl[9]  = '{2, 3, 4,  7,  0,  1,  7,  1,   0};
    tbl[10] = '{2, 0, 4,  5,  0,  1,  5,  0,   0};
    tbl[11] = '{1, 0, 99, 17, 0,  1,  17, 0,   0};
    tbl[12] = '{0, 0, 1,  2,  0,  0,  0,  0,   0};
    @(negedge clk);
    step();
    start = 1; count = 3; abort = 1; ping_done = 1;
    step();
    chk("rst req", req, 0);
    chk("rst busy", busy, 0);
    chk("rst finished", fin, 0);
    chk("rst done_cnt", done_cnt, 0);
    chk("rst timeout", tmo_err, 0);
    rst = 0;
    for (int k = 0; k < 13; k++) begin
      for (int i = 0; i < 8; i++) dly[i] = tbl[k].d;
      run(tbl[k].cnt, tbl[k].g, dly, tbl[k].ab, tbl[k].s2, n_req, fin_at, done_o, tmo_o);
      chk($sformatf("tbl%0d requests", k), n_req, tbl[k].x_req);
      chk($sformatf("tbl%0d finish edge", k), fin_at, tbl[k].x_fin);
      chk($sformatf("tbl%0d done_cnt", k), done_o, tbl[k].x_done);
      chk($sformatf("tbl%0d timeout", k), tmo_o, tbl[k].x_tmo);
    end
    start = 1; count = 4; gap = 0;
    step();
    start = 0;
    step();
    chk("mid-rst first req", req, 1);
    ping_done = 1;
    step();
    ping_done = 0;
    chk("mid-rst done_cnt before", done_cnt, 1);
    step();
    chk("mid-rst second req", req, 1);
    step();
    rst = 1;
    step();
    chk("mid-rst req", req, 0);
    chk("mid-rst busy", busy, 0);
    chk("mid-rst finished", fin, 0);
    chk("mid-rst done_cnt", done_cnt, 0);
    chk("mid-rst timeout", tmo_err, 0);
    rst = 0; ping_done = 1;
    step();
    ping_done = 0;
    chk("late done done_cnt", done_cnt, 0);
    chk("late done finished", fin, 0);
    chk("late done busy", busy, 0);
    step();
    chk("post-rst finished", fin, 0);
    chk("post-rst req", req, 0);
    for (int k = 0; k < 40; k++) begin
      int cnt, g, ab, s2;
      cnt = $urandom_range(0, 5);
      g = $urandom_range(0, 3);
      for (int i = 0; i < 8; i++) dly[i] = $urandom_range(1, 18);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
      s2 = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 40) : 0;
      run(cnt, g, dly, ab, s2, n_req, fin_at, done_o, tmo_o);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ping_seq32.md
PING_SEQ32 -- requirements
Module: ping_seq32

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports named CLK and RST.
REQ-002 Parameter: TMO_CYCLES, 1024, maximum WAIT-state cycles per ping before timeout (legal range 2..65535).
REQ-003 CLK  input  1  rising-edge clock, shared with the downstream ping engine.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 START  input  1  one-cycle pulse that begins a ping run.
REQ-006 ABORT  input  1  terminates the run in progress.
REQ-007 COUNT  input  8  number of pings in the run, latched on an accepted START.
REQ-008 GAP  input  8  idle cycles between a ping's completion and the next request, latched on an accepted START.
REQ-009 PING_DONE  input  1  one-cycle completion pulse from the downstream ping engine.
REQ-010 PING_REQUEST32  output  1  one-cycle registered request pulse to the downstream ping engine.
REQ-011 BUSY  output  1  high in every state except IDLE.
REQ-012 FINISHED  output  1  one-cycle registered pulse at the end of the run.
REQ-013 DONE_CNT  output  8  pings completed in the current or last run.
REQ-014 TIMEOUT_ERR  output  1  sticky timeout flag for the current or last run.

Function
REQ-015 SHALL implement the states IDLE, REQ, WAIT and GAP, with all outputs registered.
REQ-016 IDLE: when START=1 and COUNT!=0, SHALL latch COUNT into remaining and GAP into gap_val, clear DONE_CNT and TIMEOUT_ERR, and go to REQ.
REQ-017 IDLE: when START=1 and COUNT=0, SHALL clear DONE_CNT and TIMEOUT_ERR, pulse FINISHED in the next cycle, stay in IDLE and issue no request.
REQ-018 SHALL ignore START in any state other than IDLE (no relatch, no counter clear).
REQ-019 REQ: SHALL hold PING_REQUEST32=1 for exactly this one cycle, clear the timeout timer, and go to WAIT unconditionally.
REQ-020 Request latency: START sampled high at edge k SHALL give PING_REQUEST32=1 in the cycle that follows edge k+1.
REQ-021 WAIT: the timer SHALL increment each cycle; on PING_DONE=1, DONE_CNT SHALL increment and remaining SHALL decrement.
REQ-022 WAIT exit on PING_DONE=1:
- if remaining was 1 -> go to IDLE and pulse FINISHED;
- else if gap_val=0 -> go to REQ;
- else -> go to GAP with the gap counter loaded with gap_val.
REQ-023 WAIT timeout: when timer = TMO_CYCLES-1 and PING_DONE=0, SHALL set TIMEOUT_ERR, go to IDLE and pulse FINISHED, so WAIT lasts at most TMO_CYCLES cycles.
REQ-024 Simultaneous PING_DONE and timeout SHALL count as a completion; TIMEOUT_ERR is not set.
REQ-025 GAP: SHALL stay exactly gap_val cycles (down-counter), then go to REQ.
REQ-026 SHALL ignore PING_DONE in IDLE, REQ and GAP.
REQ-027 ABORT=1 in REQ, WAIT or GAP SHALL force IDLE at the next edge and pulse FINISHED once, holding DONE_CNT and TIMEOUT_ERR.
- ABORT has priority over PING_DONE and timeout in the same cycle.
- ABORT in IDLE has no effect.
REQ-028 DONE_CNT SHALL saturate at 255 (unreachable with legal COUNT; required for safety).
REQ-029 The timer SHALL be 16 bits with no wrap while in WAIT.

Reset
REQ-030 RST=1 at an edge SHALL force state IDLE and clear to 0: PING_REQUEST32, BUSY, FINISHED, DONE_CNT, TIMEOUT_ERR, remaining, gap_val, timer and gap counter.
REQ-031 RST SHALL override START, ABORT and PING_DONE; mid-run reset produces no FINISHED pulse.
REQ-032 After RST falls, the first START is accepted at the next edge.

Verification
REQ-033 COUNT=3, GAP=2, PING_DONE returned 5 cycles after each request -> 3 PING_REQUEST32 pulses spaced 8 cycles apart, DONE_CNT=3, one FINISHED pulse, TIMEOUT_ERR=0.
REQ-034 TMO_CYCLES=16, COUNT=2, no PING_DONE -> 1 request, FINISHED 16 cycles after WAIT entry, TIMEOUT_ERR=1, DONE_CNT=0, BUSY=0 afterward.
REQ-035 TMO_CYCLES=16, COUNT=1, PING_DONE in the 16th WAIT cycle -> DONE_CNT=1, TIMEOUT_ERR=0.
REQ-036 START with COUNT=0 -> FINISHED one cycle later, no request, BUSY stays 0.
REQ-037 COUNT=4, GAP=0: ABORT during the second WAIT, then a second START while BUSY, then RST in a later run's WAIT:
- second START is ignored;
- after ABORT, FINISHED pulses once and DONE_CNT=1;
- after RST, all outputs are 0 at the next edge and a late PING_DONE leaves DONE_CNT=0.
